pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register that replaces the hand-written inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Carries a data bundle and a control bundle through DEPTH registered slots.
- Uses a valid/ready handshake, so a stall propagates upstream without separate stall wiring.
- Supports a synchronous flush that turns every held beat into a bubble with zeroed control bits, occupancy reporting, and an optional skid entry that registers in_ready.

Parameters:
- DATA_W, 64: width of the data bundle (PC, ALU result, rd, ...); not cleared on flush.
- CTRL_W, 12: width of the control bundle (regwrite, memwrite, branch, ...); forced to 0 in every bubble.
- DEPTH, 1: number of register slots, legal range 1..4.
- OCC_W, 3: width of the occupancy output; must satisfy 2^OCC_W > DEPTH+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  block accepts the beat this cycle
- in_data  in  DATA_W  upstream data bundle
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  slot DEPTH-1 holds a beat
- out_ready  in  1  downstream accepts; 0 means stall
- out_data  out  DATA_W  registered data bundle
- out_ctrl  out  CTRL_W  registered control bundle; 0 whenever out_valid=0
- occ  out  OCC_W  number of valid beats held, skid entry included

Behaviour:
- Reset (rst_n=0, asynchronous): all slot valids=0, all ctrl=0, all data=0, occ=0. With PIPE_SKID_EN, the skid entry is also cleared. Reset release takes effect at the first clk edge with rst_n=1.
- Slot i is register set {v_i, ctrl_i, data_i}. Slot DEPTH-1 drives the out_* ports directly from registers; there is no combinational path from in_* to out_*.
- Advance rule: slot i can load when rdy_i = !v_i || rdy_(i+1), where rdy_DEPTH = out_ready.
  - On load, slot i takes slot i-1's contents; slot 0 takes in_*.
  - A slot that is drained and not refilled gets v=0 and ctrl=0; its data holds.
- in_ready = rdy_0 && !flush (without skid).
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Latency: a beat accepted at edge n appears on out_* after edge n+DEPTH-1, i.e. DEPTH cycles from the in_* presentation cycle to the first cycle it is visible at out_*. Throughput is 1 beat/cycle while out_ready=1.
- Stall: with out_ready=0 and all slots valid, every register holds and in_ready=0. Bubbles between beats are squeezed out.
- Flush (highest priority after reset):
  - At the next edge every v_i=0 and every ctrl_i=0; data is untouched. The skid entry is cleared too.
  - An output handshake in the flush cycle still counts as delivered.
  - in_ready=0 during flush, so no input transfer happens that cycle.
- Simultaneous input and output transfer with all slots full: legal, occ unchanged.
- occ: registered, equal to the popcount of valids (plus the skid valid), updated every edge. It is 0 the cycle after flush.
- in_valid=0 with stale in_data: the stale value is never loaded into a valid slot.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined:
  - Adds one skid entry {sv, sctrl, sdata} ahead of slot 0.
  - in_ready = !sv && !flush, a registered value with no combinational path from out_ready.
  - If slot 0 can load, input bypasses the skid (latency unchanged). Otherwise the beat lands in the skid, which drains into slot 0 first when rdy_0.
  - Maximum occ = DEPTH+1.
- Undefined: no skid logic; in_ready is combinational from out_ready through the slot chain as above; maximum occ = DEPTH.

Decomposition:
- Shared constants go in riscv_def.v: PIPE_DEPTH_MAX (4) and the per-boundary DATA_W/CTRL_W values for IF/ID, ID/EX, EX/MEM and MEM/WB, so top-level instantiations stay consistent.
- One natural sub-module, pipe_slot: a single {v, ctrl, data} register with load and kill inputs. It is instantiated DEPTH times (plus once for the skid when PIPE_SKID_EN is defined).

Test Plan:
- Reset mid-stream: with DEPTH=2, load beats 0xA1 and 0xA2, then assert rst_n=0 between edges -> out_valid, out_ctrl, out_data and occ read 0 immediately, without waiting for an edge.
- Streaming: DEPTH=3, out_ready=1, in_data=1..8 on consecutive cycles -> out_data=1..8 consecutively, first beat visible 3 cycles after presentation, occ settles at 3.
- Backpressure: DEPTH=2, out_ready=0 after 2 beats -> in_ready=0 and out_data held at beat 1. Release out_ready -> beats 1, 2, 3 delivered in order, none dropped or duplicated.
- Flush: DEPTH=3 full with ctrl=0xFFF, assert flush for 1 cycle -> next cycle out_valid=0, out_ctrl=0, occ=0, out_data unchanged; the beat on in_* during flush is not accepted.
- Bubble squeeze: DEPTH=4, inputs valid on alternate cycles with out_ready=0 -> slots compact and in_ready drops only when occ=4.
- PIPE_SKID_EN: DEPTH=1, out_ready deasserted in the same cycle in_valid=1, in_ready=1 -> beat captured in skid, occ=2, in_ready=0 the next cycle; on release, order is preserved.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-boundary constants: maximum stage depth and the data/control
// bundle widths used at each inter-stage boundary.
package pipe_stage_reg_pkg;

  localparam int PIPE_DEPTH_MAX = 4;

  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_DATA_W = 64;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 64;
  localparam int MEMWB_CTRL_W = 4;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One {v, ctrl, data} register slot with load and kill; 1-cycle latency.
// Kill beats load; a load of an empty source leaves a bubble with zero ctrl and held data.
module pipe_stage_reg_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill,
  input  logic              load,
  input  logic              d_v,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              v,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= 1'b0;
      ctrl <= '0;
      data <= '0;
    end else if (kill) begin
      v    <= 1'b0;
      ctrl <= '0;
    end else if (load) begin
      v    <= d_v;
      ctrl <= d_v ? d_ctrl : '0;
      // Data only follows real beats, so stale inputs never land in a slot.
      if (d_v) data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-slot pipeline register, valid/ready on both sides, flush and occupancy.
// Latency DEPTH cycles; optional skid entry (PIPE_SKID_EN) makes in_ready purely registered.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 12,
  parameter int DEPTH  = 1,
  parameter int OCC_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occ
);

  if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH out of range");
  end
  if ((1 << OCC_W) <= DEPTH + 1) begin : g_bad_occ_w
    $error("pipe_stage_reg: OCC_W too narrow");
  end

  logic [DEPTH-1:0]             v;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl;
  logic [DEPTH-1:0][DATA_W-1:0] data;
  logic [DEPTH:0]               rdy;
  logic [DEPTH-1:0]             src_v;
  logic [DEPTH-1:0][CTRL_W-1:0] src_ctrl;
  logic [DEPTH-1:0][DATA_W-1:0] src_data;
  logic                         head_v;
  logic [CTRL_W-1:0]            head_ctrl;
  logic [DATA_W-1:0]            head_data;
  logic                         in_xfer;
  logic                         skid_nv;
  logic [OCC_W-1:0]             occ_nxt;

  assign in_xfer = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  logic              sv;
  logic [CTRL_W-1:0] sctrl;
  logic [DATA_W-1:0] sdata;
  logic              skid_load;
  logic              skid_dv;

  // The skid only captures when slot 0 is blocked; otherwise input bypasses it.
  assign in_ready  = !sv && !flush;
  assign skid_load = !sv || rdy[0];
  assign skid_dv   = in_xfer && !rdy[0];
  assign skid_nv   = skid_load ? skid_dv : sv;

  pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (flush),
    .load   (skid_load),
    .d_v    (skid_dv),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .v      (sv),
    .ctrl   (sctrl),
    .data   (sdata)
  );

  assign head_v    = sv || in_xfer;
  assign head_ctrl = sv ? sctrl : in_ctrl;
  assign head_data = sv ? sdata : in_data;
`else
  assign in_ready  = rdy[0] && !flush;
  assign skid_nv   = 1'b0;
  assign head_v    = in_xfer;
  assign head_ctrl = in_ctrl;
  assign head_data = in_data;
`endif

  // Ready ripples from the output back to slot 0; an empty slot breaks the stall.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !v[i] || rdy[i+1];
    end
  end

  always_comb begin
    src_v       = '0;
    src_ctrl    = '0;
    src_data    = '0;
    src_v[0]    = head_v;
    src_ctrl[0] = head_ctrl;
    src_data[0] = head_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i]    = v[i-1];
      src_ctrl[i] = ctrl[i-1];
      src_data[i] = data[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .kill   (flush),
      .load   (rdy[i]),
      .d_v    (src_v[i]),
      .d_ctrl (src_ctrl[i]),
      .d_data (src_data[i]),
      .v      (v[i]),
      .ctrl   (ctrl[i]),
      .data   (data[i])
    );
  end

  // Occupancy is registered from the next-state valids so it tracks the slots exactly.
  always_comb begin
    occ_nxt = OCC_W'(skid_nv);
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + OCC_W'(rdy[i] ? src_v[i] : v[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     occ <= '0;
    else if (flush) occ <= '0;
    else            occ <= occ_nxt;
  end

  assign out_valid = v[DEPTH-1];
  assign out_ctrl  = ctrl[DEPTH-1];
  assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one instance per DEPTH 1..4 sharing the input side.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic [11:0] in_ctrl = '0;

  logic        ir    [1:4];
  logic        ov    [1:4];
  logic [15:0] od    [1:4];
  logic [11:0] octrl [1:4];
  logic [2:0]  occ   [1:4];

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 4; g++) begin : g_dut
    pipe_stage_reg #(.DATA_W(16), .CTRL_W(12), .DEPTH(g), .OCC_W(3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g]),
      .out_ctrl  (octrl[g]),
      .occ       (occ[g])
    );
  end

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (ov[i] !== 1'b0) begin n_bad++; $display("FAIL reset_valid d%0d: got %b want 0", i, ov[i]); end
      n_cmp++; if (occ[i] !== 3'd0) begin n_bad++; $display("FAIL reset_occ d%0d: got %0d want 0", i, occ[i]); end
      n_cmp++; if (octrl[i] !== 12'h0) begin n_bad++; $display("FAIL reset_ctrl d%0d: got %h want 0", i, octrl[i]); end
      n_cmp++; if (od[i] !== 16'h0) begin n_bad++; $display("FAIL reset_data d%0d: got %h want 0", i, od[i]); end
    end
    // Mid-stream asynchronous reset on DEPTH=2
    in_valid = 1'b1; in_data = 16'h00A1; in_ctrl = 12'h0A1;
    @(posedge clk); #1;
    in_data = 16'h00A2; in_ctrl = 12'h0A2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    n_cmp++; if (ov[2] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_valid: got %b want 1", ov[2]); end
    n_cmp++; if (od[2] !== 16'h00A1) begin n_bad++; $display("FAIL pre_rst_data: got %h want 00a1", od[2]); end
    n_cmp++; if (octrl[2] !== 12'h0A1) begin n_bad++; $display("FAIL pre_rst_ctrl: got %h want 0a1", octrl[2]); end
    n_cmp++; if (occ[2] !== 3'd2) begin n_bad++; $display("FAIL pre_rst_occ: got %0d want 2", occ[2]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ov[2] !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b want 0", ov[2]); end
    n_cmp++; if (od[2] !== 16'h0) begin n_bad++; $display("FAIL async_rst_data: got %h want 0", od[2]); end
    n_cmp++; if (octrl[2] !== 12'h0) begin n_bad++; $display("FAIL async_rst_ctrl: got %h want 0", octrl[2]); end
    n_cmp++; if (occ[2] !== 3'd0) begin n_bad++; $display("FAIL async_rst_occ: got %0d want 0", occ[2]); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic exp_v;
    int   exp_o;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8); in_data = 16'(c + 1); in_ctrl = 12'(c + 1);
      #2;
      exp_v = (c >= 3 && c <= 10);
      exp_o = 0;
      for (int b = 1; b <= 8; b++) if (b <= c && c <= b + 2) exp_o++;
      n_cmp++; if (ov[3] !== exp_v) begin n_bad++; $display("FAIL stream_valid c%0d: got %b want %b", c, ov[3], exp_v); end
      if (exp_v) begin
        n_cmp++; if (od[3] !== 16'(c - 2)) begin n_bad++; $display("FAIL stream_data c%0d: got %0d want %0d", c, od[3], c - 2); end
        n_cmp++; if (octrl[3] !== 12'(c - 2)) begin n_bad++; $display("FAIL stream_ctrl c%0d: got %0d want %0d", c, octrl[3], c - 2); end
      end
      n_cmp++; if (occ[3] !== 3'(exp_o)) begin n_bad++; $display("FAIL stream_occ c%0d: got %0d want %0d", c, occ[3], exp_o); end
      if (c < 8) begin
        n_cmp++; if (ir[3] !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, ir[3]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int nb;
    do_reset();
    q.delete();
    nb = 1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (nb <= 3); in_data = 16'(nb); in_ctrl = 12'(nb);
      out_ready = (c >= 5);
      #2;
      if (c >= 2 && c <= 4) begin
        n_cmp++; if (ov[2] !== 1'b1) begin n_bad++; $display("FAIL bp_valid c%0d: got %b want 1", c, ov[2]); end
        n_cmp++; if (od[2] !== 16'd1) begin n_bad++; $display("FAIL bp_hold_data c%0d: got %0d want 1", c, od[2]); end
      end
      if (c == 2) begin
        n_cmp++; if (occ[2] !== 3'd2) begin n_bad++; $display("FAIL bp_occ_full: got %0d want 2", occ[2]); end
      end
      if (c == 3 || c == 4) begin
        n_cmp++; if (ir[2] !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, ir[2]); end
        n_cmp++; if (occ[2] !== 3'(2 + SKID)) begin n_bad++; $display("FAIL bp_occ c%0d: got %0d want %0d", c, occ[2], 2 + SKID); end
      end
      if (ov[2] && out_ready) q.push_back(od[2]);
      if (in_valid && ir[2]) nb++;
      @(posedge clk); #1;
    end
    n_cmp++; if (q.size() !== 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", q.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] got;
      got = (i < q.size()) ? q[i] : 16'hxxxx;
      n_cmp++; if (got !== 16'(i + 1)) begin n_bad++; $display("FAIL bp_order %0d: got %h want %0d", i, got, i + 1); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 16'h0031 + 16'(k); in_ctrl = 12'hFFF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    n_cmp++; if (occ[3] !== 3'd3) begin n_bad++; $display("FAIL flush_pre_occ: got %0d want 3", occ[3]); end
    n_cmp++; if (octrl[3] !== 12'hFFF) begin n_bad++; $display("FAIL flush_pre_ctrl: got %h want fff", octrl[3]); end
    n_cmp++; if (od[3] !== 16'h0031) begin n_bad++; $display("FAIL flush_pre_data: got %h want 0031", od[3]); end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h0044;
    #1;
    n_cmp++; if (ir[3] !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", ir[3]); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (ov[3] !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", ov[3]); end
    n_cmp++; if (octrl[3] !== 12'h0) begin n_bad++; $display("FAIL flush_ctrl: got %h want 0", octrl[3]); end
    n_cmp++; if (occ[3] !== 3'd0) begin n_bad++; $display("FAIL flush_occ: got %0d want 0", occ[3]); end
    n_cmp++; if (od[3] !== 16'h0031) begin n_bad++; $display("FAIL flush_data_kept: got %h want 0031", od[3]); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (ov[3] !== 1'b0) begin n_bad++; $display("FAIL flush_no_accept c%0d: got %b want 0", c, ov[3]); end
    end
  endtask

  task automatic test_bubble();
    int eo;
    do_reset();
    eo = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2 == 0); in_data = 16'h0040 + 16'(c); in_ctrl = 12'h040 + 12'(c);
      #2;
      n_cmp++; if (occ[4] !== 3'(eo)) begin n_bad++; $display("FAIL bubble_occ c%0d: got %0d want %0d", c, occ[4], eo); end
      n_cmp++; if (ir[4] !== (eo < 4 + SKID)) begin n_bad++; $display("FAIL bubble_in_ready c%0d: got %b want %b", c, ir[4], eo < 4 + SKID); end
      if (in_valid && eo < 4 + SKID) eo++;
      @(posedge clk); #1;
    end
    n_cmp++; if (od[4] !== 16'h0040) begin n_bad++; $display("FAIL bubble_head: got %h want 0040", od[4]); end
  endtask

  task automatic test_skid();
    do_reset();
    q.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0051; in_ctrl = 12'h051;
    #2;
    n_cmp++; if (ir[1] !== 1'b1) begin n_bad++; $display("FAIL skid_first_ready: got %b want 1", ir[1]); end
    @(posedge clk); #1;
    in_data = 16'h0052; in_ctrl = 12'h052; out_ready = 1'b0;
    #2;
`ifdef PIPE_SKID_EN
    n_cmp++; if (ir[1] !== 1'b1) begin n_bad++; $display("FAIL skid_ready_held: got %b want 1", ir[1]); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    n_cmp++; if (occ[1] !== 3'd2) begin n_bad++; $display("FAIL skid_occ: got %0d want 2", occ[1]); end
    n_cmp++; if (ir[1] !== 1'b0) begin n_bad++; $display("FAIL skid_full_ready: got %b want 0", ir[1]); end
    n_cmp++; if (od[1] !== 16'h0051) begin n_bad++; $display("FAIL skid_out_data: got %h want 0051", od[1]); end
    @(posedge clk); #1;
    out_ready = 1'b1;
`else
    n_cmp++; if (ir[1] !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b want 0", ir[1]); end
    n_cmp++; if (occ[1] !== 3'd1) begin n_bad++; $display("FAIL stall_occ: got %0d want 1", occ[1]); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #2;
    n_cmp++; if (ir[1] !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", ir[1]); end
    if (ov[1] && out_ready) q.push_back(od[1]);
    @(posedge clk); #1;
    in_valid = 1'b0;
`endif
    for (int c = 0; c < 4; c++) begin
      #2;
      if (ov[1] && out_ready) q.push_back(od[1]);
      @(posedge clk); #1;
    end
    n_cmp++; if (q.size() !== 2) begin n_bad++; $display("FAIL skid_count: got %0d want 2", q.size()); end
    for (int i = 0; i < 2; i++) begin
      logic [15:0] got;
      got = (i < q.size()) ? q[i] : 16'hxxxx;
      n_cmp++; if (got !== 16'h0051 + 16'(i)) begin n_bad++; $display("FAIL skid_order %0d: got %h want %h", i, got, 16'h0051 + 16'(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_skid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
